// File: rtl/period_capture_if.sv
// Capture handshake between period_capture and its consumer.
interface period_capture_if #(
    parameter int unsigned WIDTH = 24
);
    logic [WIDTH-1:0] period_out;
    logic             valid;
    logic             ovf;
    logic             lost;
    logic             edge_pulse;
    logic             armed;
    logic             ack;

    modport master (
        output period_out, valid, ovf, lost, edge_pulse, armed,
        input  ack
    );

    modport slave (
        input  period_out, valid, ovf, lost, edge_pulse, armed,
        output ack
    );
endinterface

// File: rtl/period_capture.sv
// Measures clk-cycle intervals between qualifying edges of a filtered pulse input.
module period_capture #(
    parameter int unsigned WIDTH      = 24,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              srst,
    input  logic              edge_sel,
    input  logic              sig_in,
    period_capture_if.master  bus
);

    localparam int unsigned      FCW      = $clog2(FILTER_LEN + 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_PRE  = CNT_MAX - WIDTH'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    logic             sync1;
    logic             sync2;
    logic [FCW-1:0]   filt_cnt;
    logic             filt_level;
    logic             filt_d;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic             sat;
    logic             qual_c;
    logic             capture_c;

    // Two-flop synchronizer on the asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else if (srst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    // Glitch filter: level flips once FILTER_LEN consecutive differing samples are seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt   <= '0;
            filt_level <= 1'b0;
            filt_d     <= 1'b0;
        end else if (srst) begin
            filt_cnt   <= '0;
            filt_level <= 1'b0;
            filt_d     <= 1'b0;
        end else begin
            filt_d <= filt_level;
            if (filt_cnt == FCW'(FILTER_LEN)) begin
                filt_level <= ~filt_level;
                filt_cnt   <= '0;
            end else if (sync2 != filt_level) begin
                filt_cnt <= filt_cnt + FCW'(1);
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    // Qualifying edge of the filtered level; transitions while disabled are dropped.
    assign qual_c    = ena & (edge_sel ? (filt_d & ~filt_level) : (filt_level & ~filt_d));
    assign capture_c = qual_c & (state == ARMED);

    // Arm/measure state machine with capture register and consumer handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            sat            <= 1'b0;
            bus.period_out <= '0;
            bus.valid      <= 1'b0;
            bus.ovf        <= 1'b0;
            bus.lost       <= 1'b0;
            bus.edge_pulse <= 1'b0;
            bus.armed      <= 1'b0;
        end else if (srst) begin
            state          <= IDLE;
            cnt            <= '0;
            sat            <= 1'b0;
            bus.period_out <= '0;
            bus.valid      <= 1'b0;
            bus.ovf        <= 1'b0;
            bus.lost       <= 1'b0;
            bus.edge_pulse <= 1'b0;
            bus.armed      <= 1'b0;
        end else begin
            bus.edge_pulse <= qual_c;
            case (state)
                IDLE: begin
                    if (qual_c) begin
                        state     <= ARMED;
                        bus.armed <= 1'b1;
                        cnt       <= WIDTH'(1);
                        sat       <= 1'b0;
                    end
                end
                ARMED: begin
                    if (qual_c) begin
                        cnt <= WIDTH'(1);
                        sat <= 1'b0;
                    end else if (ena) begin
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + WIDTH'(1);
                        end
                        if (cnt >= CNT_PRE) begin
                            sat <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (capture_c) begin
                bus.period_out <= cnt;
                bus.ovf        <= sat;
                bus.valid      <= 1'b1;
                if (bus.ack) begin
                    bus.lost <= 1'b0;
                end else if (bus.valid) begin
                    bus.lost <= 1'b1;
                end
            end else if (bus.ack && bus.valid) begin
                bus.valid <= 1'b0;
                bus.lost  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_period_capture.sv
// Directed scoreboard bench for period_capture (WIDTH=8, FILTER_LEN=3).
module tb_period_capture;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic srst;
    logic edge_sel;
    logic sig_in;

    int checks = 0;
    int errors = 0;
    int now    = 0;
    int lat;

    typedef struct {
        logic       valid;
        logic       chk;
        logic [7:0] period;
        logic       ovf;
        logic       lost;
    } exp_t;

    exp_t q[$];

    period_capture_if #(.WIDTH(8)) bus ();

    period_capture #(
        .WIDTH      (8),
        .FILTER_LEN (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .srst     (srst),
        .edge_sel (edge_sel),
        .sig_in   (sig_in),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic c, input logic [7:0] p, input logic o, input logic l);
        exp_t e;
        e.valid  = v;
        e.chk    = c;
        e.period = p;
        e.ovf    = o;
        e.lost   = l;
        q.push_back(e);
    endtask

    // Advance to absolute negedge index n.
    task automatic go(input int n);
        repeat (n - now) @(negedge clk);
        now = n;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, 32'(bus.period_out), 0);
        check({tag, "_valid"},  32'(bus.valid), 0);
        check({tag, "_ovf"},    32'(bus.ovf), 0);
        check({tag, "_lost"},   32'(bus.lost), 0);
        check({tag, "_pulse"},  32'(bus.edge_pulse), 0);
        check({tag, "_armed"},  32'(bus.armed), 0);
    endtask

    // Monitor: every edge_pulse must match the next expected record.
    always @(negedge clk) begin
        if (bus.edge_pulse) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge_pulse: got pulse at t=%0t, expected none", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("mon_armed", 32'(bus.armed), 1);
                check("mon_valid", 32'(bus.valid), 32'(e.valid));
                check("mon_lost",  32'(bus.lost),  32'(e.lost));
                if (e.chk) begin
                    check("mon_period", 32'(bus.period_out), 32'(e.period));
                    check("mon_ovf",    32'(bus.ovf),        32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed stimulus; times are negedge indices relative to the first rising input.
    initial begin
        rst = 1'b0; ena = 1'b1; srst = 1'b0; edge_sel = 1'b0; sig_in = 1'b0; bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        now = 0;

        // 100-clk square wave: arm, then capture.
        sig_in = 1'b1; push(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            go(now + 1);
            if (bus.edge_pulse && lat == 0) lat = i - 1;
        end
        check("first_edge_latency", 32'(lat), 6);
        go(50);  sig_in = 1'b0;
        go(100); sig_in = 1'b1; push(1'b1, 1'b1, 8'd100, 1'b0, 1'b0);
        go(110); sig_in = 1'b0; bus.ack = 1'b1;
        go(111); bus.ack = 1'b0;
        check("ack_clears_valid_1", 32'(bus.valid), 0);

        // 2-clk glitch rejected, 3-clk pulse accepted; count runs through the glitch.
        go(130); sig_in = 1'b1;
        go(132); sig_in = 1'b0;
        go(152); sig_in = 1'b1; push(1'b1, 1'b1, 8'd52, 1'b0, 1'b0);
        go(155); sig_in = 1'b0;
        go(170); bus.ack = 1'b1;
        go(171); bus.ack = 1'b0;
        check("ack_clears_valid_2", 32'(bus.valid), 0);

        // Saturation at 255, then a normal 50-clk interval.
        go(452); sig_in = 1'b1; push(1'b1, 1'b1, 8'd255, 1'b1, 1'b0);
        go(470); sig_in = 1'b0;
        go(480); bus.ack = 1'b1;
        go(481); bus.ack = 1'b0;
        check("ack_clears_valid_3", 32'(bus.valid), 0);
        check("ack_keeps_ovf", 32'(bus.ovf), 1);
        go(502); sig_in = 1'b1; push(1'b1, 1'b1, 8'd50, 1'b0, 1'b0);

        // Overwrite without ack sets lost; ack coincident with capture clears it.
        go(522); sig_in = 1'b0;
        go(542); sig_in = 1'b1; push(1'b1, 1'b1, 8'd40, 1'b0, 1'b1);
        go(562); sig_in = 1'b0;
        go(582); sig_in = 1'b1; push(1'b1, 1'b1, 8'd40, 1'b0, 1'b0);
        go(588); bus.ack = 1'b1;
        go(589); bus.ack = 1'b0;
        go(600); bus.ack = 1'b1;
        go(601); bus.ack = 1'b0;
        check("ack_alone_valid", 32'(bus.valid), 0);
        check("ack_alone_lost",  32'(bus.lost), 0);
        go(602); sig_in = 1'b0;
        go(622); sig_in = 1'b1; push(1'b1, 1'b1, 8'd40, 1'b0, 1'b0);

        // Asynchronous reset mid-interval; next edge only re-arms.
        go(642); sig_in = 1'b0;
        go(650); rst = 1'b0;
        #1;
        check_zero("async_rst");
        go(651); rst = 1'b1;
        go(662); sig_in = 1'b1; push(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);

        // Falling-edge capture with ena gating.
        go(680); edge_sel = 1'b1;
        go(700); sig_in = 1'b0; push(1'b1, 1'b1, 8'd38, 1'b0, 1'b0);
        go(720); sig_in = 1'b1;
        go(730); bus.ack = 1'b1;
        go(731); bus.ack = 1'b0;
        check("ack_clears_valid_4", 32'(bus.valid), 0);
        go(740); ena = 1'b0;
        go(750); ena = 1'b1;
        go(780); sig_in = 1'b0; push(1'b1, 1'b1, 8'd70, 1'b0, 1'b0);
        go(800); sig_in = 1'b1;
        go(840); sig_in = 1'b0;
        go(843); ena = 1'b0;
        go(860); ena = 1'b1;
        go(880); sig_in = 1'b1;
        go(920); sig_in = 1'b0; push(1'b1, 1'b1, 8'd123, 1'b0, 1'b1);

        // Synchronous clear.
        go(935);
        check("lost_before_srst", 32'(bus.lost), 1);
        go(940); srst = 1'b1;
        go(941); srst = 1'b0;
        check_zero("srst");
        go(960);
        check("queue_empty", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
